// File: rtl/store_pkg.sv
// Shared encodings and beat payload for the store narrowing path.
package store_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BE_W        = 4;
  // Beat address field is sized for the default 32-bit address space.
  localparam int unsigned BEAT_ADDR_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef struct packed {
    logic [BEAT_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]      wdata;
    logic [BE_W-1:0]        be;
    logic                   fits;
    logic                   misalign;
  } beat_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_TWO   = 2'b10
  } skid_state_e;

endpackage

// File: rtl/store_lane_decode.sv
// Combinational size/address/data decode into a fully formed write beat.
module store_lane_decode
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  output beat_t             beat_c
);

  logic byte_fits;
  logic half_fits;

  // A truncated value fits when every bit above its sign bit equals the sign bit.
  assign byte_fits = (&data_i[31:7])  | ~(|data_i[31:7]);
  assign half_fits = (&data_i[31:15]) | ~(|data_i[31:15]);

  // Lane placement, replication and error flagging per access size.
  always_comb begin
    beat_c          = '0;
    beat_c.addr     = BEAT_ADDR_W'({addr_i[ADDR_W-1:2], 2'b00});
    beat_c.wdata    = data_i;
    unique case (size_i)
      SZ_BYTE: begin
        beat_c.be    = 4'b0001 << addr_i[1:0];
        beat_c.wdata = {4{data_i[7:0]}};
        beat_c.fits  = byte_fits;
      end
      SZ_HALF: begin
        beat_c.fits = half_fits;
        if (addr_i[0]) begin
          beat_c.misalign = 1'b1;
        end else begin
          beat_c.be    = addr_i[1] ? 4'b1100 : 4'b0011;
          beat_c.wdata = {2{data_i[15:0]}};
        end
      end
      SZ_WORD: begin
        beat_c.fits = 1'b1;
        if (addr_i[1:0] != 2'b00) begin
          beat_c.misalign = 1'b1;
        end else begin
          beat_c.be = 4'b1111;
        end
      end
      default: begin
        beat_c.misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing stage: lane decode, 2-entry skid buffer and misalign counter.
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_data,
  input  logic [1:0]        in_size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_wdata,
  output logic [3:0]        out_be,
  output logic              out_fits,
  output logic              out_misalign,
  output logic [ERR_W-1:0]  err_count
);

  skid_state_e      state_q, state_d;
  beat_t            out_q, out_d;
  beat_t            skid_q, skid_d;
  beat_t            dec_beat;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             in_xfer;
  logic             out_xfer;

  store_lane_decode #(
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr_i (in_addr),
    .data_i (in_data),
    .size_i (in_size),
    .beat_c (dec_beat)
  );

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_addr     = ADDR_W'(out_q.addr);
  assign out_wdata    = out_q.wdata;
  assign out_be       = out_q.be;
  assign out_fits     = out_q.fits;
  assign out_misalign = out_q.misalign;
  assign err_count    = err_q;

  // State, payload and counter registers; reset drops any held beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      err_q       <= err_d;
    end
  end

  // Skid next-state; handshake flags are registered from the next state.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    err_d   = err_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (in_xfer) begin
          state_d = SKID_ONE;
          out_d   = dec_beat;
        end
      end
      SKID_ONE: begin
        if (in_xfer && !out_xfer) begin
          state_d = SKID_TWO;
          skid_d  = dec_beat;
        end else if (!in_xfer && out_xfer) begin
          state_d = SKID_EMPTY;
        end else if (in_xfer && out_xfer) begin
          out_d = dec_beat;
        end
      end
      SKID_TWO: begin
        if (out_xfer) begin
          state_d = SKID_ONE;
          out_d   = skid_q;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    if (in_xfer && dec_beat.misalign && (err_q != '1)) begin
      err_d = err_q + ERR_W'(1);
    end
    out_valid_d = (state_d != SKID_EMPTY);
    in_ready_d  = (state_d != SKID_TWO);
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit.
module tb_store_narrow_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_fits;
  logic        out_misalign;
  logic [7:0]  err_count;
  logic [70:0] obs;

  int n_tests;
  int n_fail;

  store_narrow_unit #(
    .ADDR_W (32),
    .ERR_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .in_size      (in_size),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_addr     (out_addr),
    .out_wdata    (out_wdata),
    .out_be       (out_be),
    .out_fits     (out_fits),
    .out_misalign (out_misalign),
    .err_count    (err_count)
  );

  assign obs = {out_valid, out_addr, out_wdata, out_be, out_fits, out_misalign};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  // Independent reference: lane-by-lane placement and sign-extension round trip.
  function automatic logic [70:0] model(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] s);
    logic [31:0] ea;
    logic [31:0] ew;
    logic [3:0]  ebe;
    logic        ef;
    logic        em;
    ea  = {a[31:2], 2'b00};
    ebe = 4'b0000;
    ew  = d;
    case (s)
      2'b00: begin
        em = 1'b0;
        ef = ({{24{d[7]}}, d[7:0]} == d);
        ew = 32'({24'h0, d[7:0]}) * 32'h01010101;
        ebe[a[1:0]] = 1'b1;
      end
      2'b01: begin
        em = a[0];
        ef = ({{16{d[15]}}, d[15:0]} == d);
        if (!em) begin
          ew = 32'({16'h0, d[15:0]}) * 32'h00010001;
          ebe = a[1] ? 4'b1100 : 4'b0011;
        end
      end
      2'b10: begin
        em = (a[1:0] != 2'b00);
        ef = 1'b1;
        if (!em) ebe = 4'b1111;
      end
      default: begin
        em = 1'b1;
        ef = 1'b0;
      end
    endcase
    return {1'b1, ea, ew, ebe, ef, em};
  endfunction

  task automatic test_reset;
    #12;
    n_tests++;
    if (obs !== 71'h0) begin
      n_fail++;
      $display("FAIL reset_beat got %h want %h", obs, 71'h0);
    end
    n_tests++;
    if ({in_ready, err_count} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_ready_err got %b/%h want 1/00", in_ready, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_byte;
    out_ready = 1'b1;
    drive(1'b1, 32'h1002, 32'hFFFFFF80, 2'b00);
    tick;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    n_tests++;
    if (obs !== {1'b1, 32'h1000, 32'h80808080, 4'b0100, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL byte_beat got %h want %h", obs,
               {1'b1, 32'h1000, 32'h80808080, 4'b0100, 1'b1, 1'b0});
    end
    tick;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_half;
    out_ready = 1'b1;
    drive(1'b1, 32'h2002, 32'h00018000, 2'b01);
    tick;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    n_tests++;
    if (obs !== {1'b1, 32'h2000, 32'h80008000, 4'b1100, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL half_beat got %h want %h", obs,
               {1'b1, 32'h2000, 32'h80008000, 4'b1100, 1'b0, 1'b0});
    end
    tick;
  endtask

  task automatic test_misalign;
    out_ready = 1'b1;
    drive(1'b1, 32'h3001, 32'h12345678, 2'b10);
    tick;
    n_tests++;
    if (obs !== {1'b1, 32'h3000, 32'h12345678, 4'b0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL misalign_beat got %h want %h", obs,
               {1'b1, 32'h3000, 32'h12345678, 4'b0000, 1'b1, 1'b1});
    end
    n_tests++;
    if (err_count !== 8'h01) begin
      n_fail++;
      $display("FAIL misalign_err1 got %h want 01", err_count);
    end
    for (int k = 1; k <= 300; k++) begin
      tick;
      if (k == 253) begin
        n_tests++;
        if (err_count !== 8'hFE) begin
          n_fail++;
          $display("FAIL misalign_err_fe got %h want fe", err_count);
        end
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick;
    n_tests++;
    if ({out_valid, err_count} !== {1'b0, 8'hFF}) begin
      n_fail++;
      $display("FAIL misalign_saturate got %b/%h want 0/ff", out_valid, err_count);
    end
  endtask

  task automatic test_backpressure;
    logic [70:0] ba;
    logic [70:0] bb;
    logic [70:0] bc;
    ba = {1'b1, 32'h100, 32'hAAAA0001, 4'b1111, 1'b1, 1'b0};
    bb = {1'b1, 32'h200, 32'h5B5B5B5B, 4'b0010, 1'b1, 1'b0};
    bc = {1'b1, 32'h300, 32'h80018001, 4'b1100, 1'b1, 1'b0};
    out_ready = 1'b0;
    drive(1'b1, 32'h100, 32'hAAAA0001, 2'b10);
    tick;
    n_tests++;
    if ({in_ready, obs} !== {1'b1, ba}) begin
      n_fail++;
      $display("FAIL bp_first got %b/%h want 1/%h", in_ready, obs, ba);
    end
    drive(1'b1, 32'h201, 32'h0000005B, 2'b00);
    tick;
    drive(1'b1, 32'h302, 32'hFFFF8001, 2'b01);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({in_ready, obs} !== {1'b0, ba}) begin
        n_fail++;
        $display("FAIL bp_stall%0d got %b/%h want 0/%h", k, in_ready, obs, ba);
      end
      if (k < 2) tick;
    end
    out_ready = 1'b1;
    tick;
    n_tests++;
    if ({in_ready, obs} !== {1'b1, bb}) begin
      n_fail++;
      $display("FAIL bp_second got %b/%h want 1/%h", in_ready, obs, bb);
    end
    tick;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    n_tests++;
    if (obs !== bc) begin
      n_fail++;
      $display("FAIL bp_third got %h want %h", obs, bc);
    end
    tick;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_throughput;
    logic [31:0] ta [16];
    logic [31:0] td [16];
    logic [1:0]  ts [16];
    logic [70:0] exp_beat;
    for (int i = 0; i < 16; i++) begin
      ta[i] = $urandom;
      td[i] = $urandom;
      ts[i] = 2'($urandom_range(0, 3));
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, ta[i], td[i], ts[i]);
      tick;
      exp_beat = model(ta[i], td[i], ts[i]);
      n_tests++;
      if ({in_ready, obs} !== {1'b1, exp_beat}) begin
        n_fail++;
        $display("FAIL thru_beat%0d got %b/%h want 1/%h", i, in_ready, obs, exp_beat);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    tick;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL thru_drain got %b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive(1'b1, 32'h4000, 32'h00000001, 2'b10);
    tick;
    drive(1'b1, 32'h4005, 32'h00000002, 2'b10);
    tick;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    n_tests++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_fail++;
      $display("FAIL ar_full got %b%b want 01", in_ready, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({obs, in_ready, err_count} !== {71'h0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL ar_immediate got %h/%b/%h want 0/1/00", obs, in_ready, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      n_tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_fail++;
        $display("FAIL ar_no_stale%0d got %b%b want 01", k, out_valid, in_ready);
      end
    end
    drive(1'b1, 32'h5003, 32'hCAFE00A5, 2'b00);
    tick;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    n_tests++;
    if ({obs, err_count} !== {1'b1, 32'h5000, 32'hA5A5A5A5, 4'b1000, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL ar_fresh got %h/%h want %h/00", obs, err_count,
               {1'b1, 32'h5000, 32'hA5A5A5A5, 4'b1000, 1'b0, 1'b0});
    end
    tick;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 2'b00);
    test_reset;
    test_byte;
    test_half;
    test_misalign;
    test_backpressure;
    test_throughput;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load-path sign extender. It takes a full 32-bit register value plus a byte address and an access size, and narrows it onto the memory write lanes.
- Outputs are the replicated write data, a byte-enable mask, a word-aligned address, a signed-fit flag and a misalignment flag.
- Sits between the EX/MEM stage and the data-memory write port.
- Valid/ready on both sides, 1-cycle registered latency, full throughput via a 2-entry skid buffer.

Parameters:
- ADDR_W, 32, address width.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request
- in_addr  input  ADDR_W  byte address
- in_data  input  32  register value to store
- in_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- out_valid  output  1  write beat valid
- out_ready  input  1  memory accepts beat
- out_addr  output  ADDR_W  in_addr with bits [1:0] cleared
- out_wdata  output  32  lane-replicated data
- out_be  output  4  byte enables, bit i = byte lane i (little-endian)
- out_fits  output  1  truncated value sign-extends back to in_data
- out_misalign  output  1  misaligned or reserved size; out_be forced to 0
- err_count  output  ERR_W  saturating count of accepted requests with out_misalign=1

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_addr/out_wdata/out_be=0, out_fits=0, out_misalign=0, err_count=0, skid empty, in_ready=1.
- Transfer rules: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Latency: a request accepted in cycle N appears on out_* in cycle N+1 if the output register is free.
- Lane rules, byte (00):
  - out_be = 4'b0001 << addr[1:0]
  - out_wdata = {4{data[7:0]}}
  - out_fits = data[31:7] all-equal
- Lane rules, half (01):
  - addr[0] must be 0.
  - out_be = addr[1] ? 1100 : 0011
  - out_wdata = {2{data[15:0]}}
  - out_fits = data[31:15] all-equal
- Lane rules, word (10):
  - addr[1:0] must be 00.
  - out_be = 1111, out_wdata = data, out_fits = 1.
- Error cases: a misaligned half/word or size 11 gives out_misalign=1, out_be=0000, out_wdata = data unchanged, out_fits computed per size (0 for size 11).
- Skid FSM, states EMPTY, ONE (out reg full), TWO (out reg + skid full). in_ready = (state != TWO), driven from a register, no combinational path from out_ready.
  - EMPTY: on input transfer -> ONE.
  - ONE:
    - input transfer and no output transfer -> TWO (request goes to skid).
    - output transfer and no input transfer -> EMPTY.
    - both -> stay ONE, output register reloads with the new request.
  - TWO: on output transfer, the skid entry moves to the output register -> ONE.
- out_* must stay stable while out_valid & !out_ready.
- err_count increments by 1 when a request with misalign=1 is accepted at the input (not at output). It saturates at all-ones.
- Reset mid-operation: both entries are discarded immediately and no partial beat is emitted.
- Pure-combinational lane/fit computation is applied before registering; both stored entries carry fully decoded fields.

Decomposition:
- Shared package store_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - a packed beat typedef {addr, wdata, be, fits, misalign}.
  - skid state enum.
- One natural sub-module: store_lane_decode, the combinational size/addr/data to beat-fields decoder. The skid/FSM and counter stay in the top.

Test Plan:
- Byte store: addr=0x1002, data=0xFFFFFF80, size=00 -> next cycle out_addr=0x1000, be=0100, wdata=0x80808080, fits=1, misalign=0.
- Half store non-fitting: addr=0x2002, data=0x00018000, size=01 -> be=1100, wdata=0x80008000, fits=0.
- Misaligned word: addr=0x3001, size=10 -> be=0000, misalign=1, err_count 0->1. Then 300 more misaligned requests -> err_count holds 0xFF.
- Backpressure: three requests back-to-back with out_ready=0 -> first two accepted, in_ready=0 from the cycle after the second acceptance, out_* stable. Raise out_ready -> beats emitted in order, third accepted, no loss or duplication.
- Full throughput: 16 random requests with in_valid=out_ready=1 continuously -> one beat per cycle, each beat equal to the reference model, latency 1.
- Async reset asserted while in state TWO -> out_valid=0 and err_count=0 immediately, in_ready=1 after release, no stale beat appears.
